// File: rtl/router_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : router_port_buffer
//  Description : Credit-based flit FIFO between a router local output port
//                and the ddma receive side. Tracks packet framing
//                (header, size, payload) on the pop side and flags packet
//                start/end. Optional statistics via macro PKT_STATS_EN
//                (pkt_count_o, drop_o).
//  Revision    : 1.0 - initial release
// ============================================================================
module router_port_buffer #(
    parameter int FLIT_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx_i,
    input  logic [FLIT_WIDTH-1:0]   data_i,
    output logic                    credit_o,
    output logic                    tx_o,
    output logic [FLIT_WIDTH-1:0]   data_o,
    input  logic                    credit_i,
    output logic                    pkt_start_o,
    output logic                    pkt_end_o,
    output logic [$clog2(DEPTH):0]  level_o
`ifdef PKT_STATS_EN
    ,
    output logic [31:0]             pkt_count_o,
    output logic [0:0]              drop_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [1:0] c_F_HEADER  = 2'd0;
    localparam logic [1:0] c_F_SIZE    = 2'd1;
    localparam logic [1:0] c_F_PAYLOAD = 2'd2;

    localparam logic [LW-1:0]         c_FULL = LW'(DEPTH);
    localparam logic [FLIT_WIDTH-1:0] c_ONE  = FLIT_WIDTH'(1);

    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [FLIT_WIDTH-1:0] r_cnt;

    logic                  w_push;
    logic                  w_pop;

    // Credit is derived from the level before any pop of this cycle, so a
    // full buffer refuses a push even while it is being drained.
    assign credit_o = (r_level != c_FULL);
    assign tx_o     = (r_level != '0);
    assign data_o   = tx_o ? r_mem[r_rd_ptr] : '0;
    assign level_o  = r_level;
    assign w_push   = rx_i && credit_o;
    assign w_pop    = tx_o && credit_i;

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Framing state register and remaining-payload counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_F_HEADER;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop && r_state == c_F_SIZE) begin
                r_cnt <= data_o;
            end else if (w_pop && r_state == c_F_PAYLOAD) begin
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

    // Framing next state; moves only on a pop.
    always_comb begin
        w_state_nxt = r_state;
        if (w_pop) begin
            case (r_state)
                c_F_HEADER:  w_state_nxt = c_F_SIZE;
                c_F_SIZE:    w_state_nxt = (data_o == '0) ? c_F_HEADER : c_F_PAYLOAD;
                c_F_PAYLOAD: w_state_nxt = (r_cnt == c_ONE) ? c_F_HEADER : c_F_PAYLOAD;
                default:     w_state_nxt = c_F_HEADER;
            endcase
        end
    end

    // Framing flags, qualified by the pop so they never fire on a stall.
    always_comb begin
        pkt_start_o = 1'b0;
        pkt_end_o   = 1'b0;
        if (w_pop) begin
            case (r_state)
                c_F_HEADER:  pkt_start_o = 1'b1;
                c_F_SIZE:    pkt_end_o   = (data_o == '0);
                c_F_PAYLOAD: pkt_end_o   = (r_cnt == c_ONE);
                default:     pkt_start_o = 1'b0;
            endcase
        end
    end

`ifdef PKT_STATS_EN
    logic [31:0] r_pkt_count;
    logic        r_drop;

    // Completed-packet counter and one-cycle drop pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pkt_count <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= rx_i && !credit_o;
            if (w_pop && pkt_end_o) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign pkt_count_o = r_pkt_count;
    assign drop_o      = r_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_port_buffer
//  Description : Self-checking bench for router_port_buffer: vector table
//                for single packet, fill/drop, full simultaneous push/pop,
//                zero-size packets; hand sequences for mid-packet reset and
//                a randomly stalled multi-packet stream across pointer wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_port_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_i;
    logic [15:0] data_i;
    logic        credit_o;
    logic        tx_o;
    logic [15:0] data_o;
    logic        credit_i;
    logic        pkt_start_o;
    logic        pkt_end_o;
    logic [3:0]  level_o;
`ifdef PKT_STATS_EN
    logic [31:0] pkt_count_o;
    logic [0:0]  drop_o;
`endif

    router_port_buffer #(.FLIT_WIDTH(16), .DEPTH(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_i        (rx_i),
        .data_i      (data_i),
        .credit_o    (credit_o),
        .tx_o        (tx_o),
        .data_o      (data_o),
        .credit_i    (credit_i),
        .pkt_start_o (pkt_start_o),
        .pkt_end_o   (pkt_end_o),
        .level_o     (level_o)
`ifdef PKT_STATS_EN
        ,
        .pkt_count_o (pkt_count_o),
        .drop_o      (drop_o)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rx;
        logic [15:0] din;
        logic        ci;
        logic        credit;
        logic        tx;
        logic [15:0] dout;
        logic        st;
        logic        en;
        logic [3:0]  lvl;
        logic        drop;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input logic rx, input logic [15:0] din, input logic ci,
                                input logic credit, input logic tx, input logic [15:0] dout,
                                input logic st, input logic en, input logic [3:0] lvl,
                                input logic drop);
        vec_t v;
        v.rx = rx; v.din = din; v.ci = ci; v.credit = credit; v.tx = tx;
        v.dout = dout; v.st = st; v.en = en; v.lvl = lvl; v.drop = drop;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one vector after a falling edge, check just after, advance a cycle.
    task automatic apply(input int idx);
        vec_t v;
        v = tbl[idx];
        rx_i = v.rx; data_i = v.din; credit_i = v.ci;
        #1;
        n_vec++;
        chk($sformatf("v%0d credit_o", idx), 32'(credit_o), 32'(v.credit));
        chk($sformatf("v%0d tx_o", idx), 32'(tx_o), 32'(v.tx));
        chk($sformatf("v%0d data_o", idx), 32'(data_o), 32'(v.dout));
        chk($sformatf("v%0d pkt_start_o", idx), 32'(pkt_start_o), 32'(v.st));
        chk($sformatf("v%0d pkt_end_o", idx), 32'(pkt_end_o), 32'(v.en));
        chk($sformatf("v%0d level_o", idx), 32'(level_o), 32'(v.lvl));
`ifdef PKT_STATS_EN
        chk($sformatf("v%0d drop_o", idx), 32'(drop_o), 32'(v.drop));
`endif
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0; rx_i = 1'b0; data_i = '0; credit_i = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic drive(input logic rx, input logic [15:0] din, input logic ci);
        rx_i = rx; data_i = din; credit_i = ci;
        @(negedge clock);
    endtask

    initial begin
        logic [15:0] f2 [8];
        logic [15:0] f4 [5];
        logic [15:0] exp6 [24];
        int t4_lo, t4_hi;
        int sent, popped, cyc;
        logic rx_d, ci_d;
`ifdef PKT_STATS_EN
        logic [31:0] cnt_before;
`endif

        // ---- T1: single packet, credit_i held high ----
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 16'hA001, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 16'h0002, 1, 1, 1, 16'hA001, 1, 0, 1, 0);
        add(1, 16'h1111, 1, 1, 1, 16'h0002, 0, 0, 1, 0);
        add(1, 16'h2222, 1, 1, 1, 16'h1111, 0, 0, 1, 0);
        add(0, 16'h0000, 1, 1, 1, 16'h2222, 0, 1, 1, 0);
        add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 0, 0);

        // ---- T2: fill to 8 with credit_i low, then drop a 9th ----
        f2[0] = 16'hD000; f2[1] = 16'h0006;
        for (int k = 2; k < 8; k++) f2[k] = 16'h1000 + 16'(k - 1);
        for (int k = 0; k < 8; k++)
            add(1, f2[k], 0, 1, k > 0, (k > 0) ? 16'hD000 : 16'h0000, 0, 0, 4'(k), 0);
        add(1, 16'hDEAD, 0, 0, 1, 16'hD000, 0, 0, 8, 0);
        // ---- T3: full, push and pop together: pop wins, push refused ----
        add(1, 16'hBEEF, 1, 0, 1, 16'hD000, 1, 0, 8, 1);
        add(0, 16'h0000, 1, 1, 1, 16'h0006, 0, 0, 7, 1);
        for (int k = 1; k <= 6; k++)
            add(0, 16'h0000, 1, 1, 1, 16'h1000 + 16'(k), 0, k == 6, 4'(7 - k), 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 0);

        // ---- T4: zero-size packet then one-payload packet ----
        t4_lo = tbl.size();
        f4[0] = 16'hB000; f4[1] = 16'h0000; f4[2] = 16'hC000; f4[3] = 16'h0001; f4[4] = 16'h3333;
        for (int k = 0; k < 5; k++)
            add(1, f4[k], 0, 1, k > 0, (k > 0) ? 16'hB000 : 16'h0000, 0, 0, 4'(k), 0);
        add(0, 16'h0000, 1, 1, 1, 16'hB000, 1, 0, 5, 0);
        add(0, 16'h0000, 1, 1, 1, 16'h0000, 0, 1, 4, 0);
        add(0, 16'h0000, 1, 1, 1, 16'hC000, 1, 0, 3, 0);
        add(0, 16'h0000, 1, 1, 1, 16'h0001, 0, 0, 2, 0);
        add(0, 16'h0000, 1, 1, 1, 16'h3333, 0, 1, 1, 0);
        add(0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
        t4_hi = tbl.size();

        // Reset held for two cycles
        reset = 1'b0; rx_i = 1'b0; data_i = '0; credit_i = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < t4_lo; i++) apply(i);
`ifdef PKT_STATS_EN
        n_vec++;
        chk("pkt_count before T4", pkt_count_o, 32'd2);
        cnt_before = pkt_count_o;
`endif
        for (int i = t4_lo; i < t4_hi; i++) apply(i);
`ifdef PKT_STATS_EN
        n_vec++;
        chk("pkt_count T4 delta", pkt_count_o - cnt_before, 32'd2);
`endif

        // ---- T5: reset in the middle of a packet ----
        do_reset();
        drive(1, 16'hE000, 1);
        drive(1, 16'h0005, 1);
        drive(1, 16'h2001, 1);
        drive(1, 16'h2002, 1);
        drive(1, 16'h2003, 0);
        #1;
        n_vec++;
        chk("T5 level before reset", 32'(level_o), 32'd2);
        do_reset();
        credit_i = 1'b1;
        #1;
        n_vec++;
        chk("T5 level_o", 32'(level_o), 32'd0);
        chk("T5 tx_o", 32'(tx_o), 32'd0);
        chk("T5 credit_o", 32'(credit_o), 32'd1);
        chk("T5 data_o", 32'(data_o), 32'd0);
        chk("T5 pkt_start_o idle", 32'(pkt_start_o), 32'd0);
        chk("T5 pkt_end_o idle", 32'(pkt_end_o), 32'd0);
`ifdef PKT_STATS_EN
        chk("T5 pkt_count_o", pkt_count_o, 32'd0);
        chk("T5 drop_o", 32'(drop_o), 32'd0);
`endif
        @(negedge clock);
        drive(1, 16'hF000, 0);
        rx_i = 1'b0; credit_i = 1'b1;
        #1;
        n_vec++;
        chk("T5 pkt_start_o", 32'(pkt_start_o), 32'd1);
        chk("T5 data_o hdr", 32'(data_o), 32'hF000);
        chk("T5 pkt_end_o", 32'(pkt_end_o), 32'd0);
        @(negedge clock);

        // ---- T6: three size-6 packets with random stalls across wrap ----
        do_reset();
        for (int p = 0; p < 3; p++) begin
            exp6[p*8]     = 16'h5A00 + 16'(p);
            exp6[p*8 + 1] = 16'h0006;
            for (int k = 0; k < 6; k++) exp6[p*8 + 2 + k] = 16'(p * 16 + k + 1) + 16'h0300;
        end
        sent = 0; popped = 0; cyc = 0;
        while (popped < 24 && cyc < 1000) begin
            rx_d = (sent < 24) && credit_o && ($urandom_range(0, 3) != 0);
            ci_d = ($urandom_range(0, 2) != 0);
            rx_i = rx_d; data_i = rx_d ? exp6[sent] : 16'h0000; credit_i = ci_d;
            #1;
            if (tx_o && credit_i) begin
                n_vec++;
                chk($sformatf("T6 data %0d", popped), 32'(data_o), 32'(exp6[popped]));
                chk($sformatf("T6 start %0d", popped), 32'(pkt_start_o), 32'(popped % 8 == 0));
                chk($sformatf("T6 end %0d", popped), 32'(pkt_end_o), 32'(popped % 8 == 7));
                popped++;
            end else begin
                n_vec++;
                chk($sformatf("T6 stall start c%0d", cyc), 32'(pkt_start_o), 32'd0);
                chk($sformatf("T6 stall end c%0d", cyc), 32'(pkt_end_o), 32'd0);
            end
            if (rx_d) sent++;
            @(negedge clock);
            cyc++;
        end
        n_vec++;
        chk("T6 flits drained", popped, 32'd24);
        rx_i = 1'b0; credit_i = 1'b0;
        #1;
        chk("T6 final level", 32'(level_o), 32'd0);
`ifdef PKT_STATS_EN
        chk("T6 pkt_count", pkt_count_o, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
